// File: rtl/sha_bridge_pkg.sv
// ============================================================================
// Module : sha_bridge_pkg
// Brief  : Shared types and derived constants for the bus-to-SHA bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sha_bridge_pkg;

  // Bridge control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bridge_state_t;

  // Default configuration
  localparam int DEF_BUS_W   = 8;
  localparam int DEF_MSG_W   = 512;
  localparam int DEF_DIG_W   = 256;
  localparam int DEF_TIMEOUT = 1023;

  // Number of bus words in a field of total_w bits
  function automatic int words(input int total_w, input int bus_w);
    return total_w / bus_w;
  endfunction

  // Address width for n words; never narrower than one bit
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Derived constants for the default configuration
  localparam int MSG_WORDS = words(DEF_MSG_W, DEF_BUS_W);
  localparam int DIG_WORDS = words(DEF_DIG_W, DEF_BUS_W);
  localparam int MSG_AW    = addr_w(MSG_WORDS);
  localparam int DIG_AW    = addr_w(DIG_WORDS);

endpackage

`default_nettype wire

// File: rtl/sha_bridge_fsm.sv
// ============================================================================
// Module : sha_bridge_fsm
// Brief  : IDLE/RUN/DONE control with watchdog; drives busy, done, err and
//          the core start pulse, all registered.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sha_bridge_fsm
  import sha_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_wr_en,
  input  logic          i_wr_ok,
  input  logic          i_core_done,
  output bridge_state_t o_state,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_core_start
);

  localparam int C_WD_W = $clog2(TIMEOUT + 1);

  bridge_state_t     r_state;
  logic [C_WD_W-1:0] r_wd;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_core_start;
  logic [C_WD_W-1:0] w_wd_next;

  assign w_wd_next = r_wd + C_WD_W'(1);

  // State, watchdog and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wd         <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_core_start <= 1'b0;
    end else begin
      r_err        <= 1'b0;
      r_core_start <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_wr_en && !i_wr_ok) begin
            r_err <= 1'b1;
          end
          if (i_start) begin
            r_state      <= ST_RUN;
            r_core_start <= 1'b1;
            r_wd         <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end else if ((r_state == ST_DONE) && i_wr_en && i_wr_ok) begin
            // A buffer write invalidates the digest
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_wr_en || i_start) begin
            r_err <= 1'b1;
          end
          if (i_core_done) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_wd    <= '0;
          end else if (32'(w_wd_next) == TIMEOUT) begin
            // Count reaches TIMEOUT on this edge: err is high in that cycle
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_wd    <= '0;
          end else begin
            r_wd <= w_wd_next;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_core_start = r_core_start;

endmodule

`default_nettype wire

// File: rtl/sha_bus_bridge.sv
// ============================================================================
// Module : sha_bus_bridge
// Brief  : Loads a message block into a SHA-256 core one bus word at a time,
//          starts the core and returns the digest word by word.
//          Option macro SHA_BRIDGE_AUTOSTART_EN: a write to the last message
//          word in IDLE or DONE also starts a hash.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sha_bus_bridge
  import sha_bridge_pkg::*;
#(
  parameter int BUS_W   = DEF_BUS_W,
  parameter int MSG_W   = DEF_MSG_W,
  parameter int DIG_W   = DEF_DIG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_wr_en,
  input  logic [addr_w(words(MSG_W, BUS_W))-1:0] i_wr_addr,
  input  logic [BUS_W-1:0]                      i_wr_data,
  input  logic                                  i_start_req,
  input  logic                                  i_rd_en,
  input  logic [addr_w(words(DIG_W, BUS_W))-1:0] i_rd_addr,
  output logic [BUS_W-1:0]                      o_rd_data,
  output logic                                  o_rd_valid,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_err,
  output logic [MSG_W-1:0]                      o_core_msg,
  output logic                                  o_core_start,
  input  logic                                  i_core_done,
  input  logic [DIG_W-1:0]                      i_core_digest
);

  localparam int C_MSG_WORDS = words(MSG_W, BUS_W);
  localparam int C_DIG_WORDS = words(DIG_W, BUS_W);
  localparam int C_MSG_IW    = addr_w(MSG_W);
  localparam int C_DIG_IW    = addr_w(DIG_W);

  bridge_state_t        w_state;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic                 w_start;
  logic [C_MSG_IW-1:0]  w_wr_base;
  logic [C_DIG_IW-1:0]  w_rd_base;
  logic [MSG_W-1:0]     r_msg;
  logic [DIG_W-1:0]     r_dig;
  logic [BUS_W-1:0]     r_rd_data;
  logic                 r_rd_valid;

  assign w_wr_ok   = (32'(i_wr_addr) < C_MSG_WORDS);
  assign w_rd_ok   = (32'(i_rd_addr) < C_DIG_WORDS);
  assign w_wr_base = C_MSG_IW'(i_wr_addr) * C_MSG_IW'(BUS_W);
  assign w_rd_base = C_DIG_IW'(i_rd_addr) * C_DIG_IW'(BUS_W);

`ifdef SHA_BRIDGE_AUTOSTART_EN
  assign w_start = i_start_req | (i_wr_en & (32'(i_wr_addr) == (C_MSG_WORDS - 1)));
`else
  assign w_start = i_start_req;
`endif

  sha_bridge_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_start),
    .i_wr_en      (i_wr_en),
    .i_wr_ok      (w_wr_ok),
    .i_core_done  (i_core_done),
    .o_state      (w_state),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_core_start (o_core_start)
  );

  // Message buffer: writes accepted outside RUN; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg <= '0;
    end else if (i_wr_en && w_wr_ok && (w_state != ST_RUN)) begin
      r_msg[w_wr_base +: BUS_W] <= i_wr_data;
    end
  end

  // Digest register captures the core result only while a hash is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig <= '0;
    end else if ((w_state == ST_RUN) && i_core_done) begin
      r_dig <= i_core_digest;
    end
  end

  // Registered read port: zero unless DONE and the address is in range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en && (w_state == ST_DONE) && w_rd_ok) begin
        r_rd_data <= r_dig[w_rd_base +: BUS_W];
      end else begin
        r_rd_data <= '0;
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_core_msg = r_msg;

endmodule

`default_nettype wire
